ppu_pixel_fifo: RTL and testbench
=================================

// Module: ppu_pixel_fifo
// PURPOSE
//  Parametrised PPU pixel FIFO, successor to the fixed 8-pixel shift register in the PPU.
//  Accepts whole bitplane tile rows from the fetcher and emits one pixel per cycle to the LCD path.
//  Supports >1 row buffered, consumer stall, flush on line start/window switch, SCX fine-scroll discard.
//  Sits between the PPU fetch state machine and the pixel output (PX_OUT/PX_valid).
// PARAMETERS
//  DEPTH   16  pixel entries in circular buffer; power of two, DEPTH >= ROW_W
//  ROW_W   8   pixels per pushed row (bits per bitplane)
//  PLANES  2   bitplanes per row = bits per pixel colour index
// PORTS
//  clk         in   1                   clock
//  rst         in   1                   synchronous active-high reset
//  flush       in   1                   clear FIFO contents, latch discard_n
//  discard_n   in   3                   pixels to drop after flush (SCX[2:0])
//  row_data    in   PLANES*ROW_W        plane p at [p*ROW_W +: ROW_W]; plane 0 = index LSB
//  row_valid   in   1                   fetcher offers a row
//  row_ready   out  1                   FIFO accepts row this cycle
//  pop_en      in   1                   consumer may take a pixel this cycle
//  palette     in   (1<<PLANES)*PLANES  palette register (BGP for PLANES=2)
//  px_out      out  PLANES              pixel colour (index or shade, see CONFIGURATION)
//  px_valid    out  1                   px_out holds a real pixel
//  level       out  $clog2(DEPTH)+1     entries currently stored
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): rd/wr pointers 0, level 0, discard_cnt 0, px_out 0, px_valid 0.
//    rst mid-row discards everything; no pixel from before reset ever appears.
//  - row_ready = !flush && !rst && (level <= DEPTH-ROW_W); combinational from registered level.
//  - Push: row_valid && row_ready -> ROW_W entries written at wr_ptr..wr_ptr+ROW_W-1 (mod DEPTH);
//    entry k = pixel from bit (ROW_W-1-k) of each plane (MSB first); wr_ptr += ROW_W mod DEPTH.
//  - Pop: pop_en && level!=0 -> head entry read, rd_ptr += 1 mod DEPTH.
//    - discard_cnt!=0: popped pixel dropped, discard_cnt -= 1, px_valid<=0 next cycle.
//    - else px_out<=head pixel, px_valid<=1 next cycle (latency 1 clk from pop).
//  - No pop (pop_en=0 or empty): px_valid<=0, px_out holds last value.
//  - level update: +ROW_W on push, -1 on pop, both in same cycle -> +ROW_W-1; never exceeds DEPTH.
//  - Push to empty FIFO: first pixel poppable the following cycle (no bypass).
//  - flush: pointers/level <= 0, discard_cnt <= discard_n, px_valid <= 0; push and pop that
//    cycle ignored (flush wins over all). rst wins over flush.
//  - Pointers wrap modulo DEPTH; level==DEPTH is full, level==0 is empty; overflow impossible
//    by row_ready rule, underflow impossible by pop gating.
//  - Control: no FSM beyond counters; discard phase is the state discard_cnt!=0.
// CONFIGURATION
//  PPU_FIFO_PALETTE_EN defined: px_out <= palette[idx*PLANES +: PLANES] (shade; BGP mapping
//    done in FIFO, registered with same 1-clk latency).
//  PPU_FIFO_PALETTE_EN undefined: px_out <= raw colour index; palette port unused.
// TESTING
//  1 Push row_data={hi=8'hCC,lo=8'hF0}, pop_en=1 -> px_out 3,3,1,1,2,2,0,0, px_valid 8 clk, level 8->0.
//  2 PALETTE_EN, palette=8'h1B, same row -> 0,0,2,2,1,1,3,3; palette=8'hE4 -> identical to raw.
//  3 pop_en=0, push 2 rows -> level 16, row_ready 0; third row held valid; pop 8 -> accepted the
//    cycle level==8; push+pop same cycle -> level +7.
//  4 flush with discard_n=3, push row of test 1, pop_en=1 -> 3 pops with px_valid=0, then 1,2,2,0,0.
//  5 level 12 mid-stream, flush with row_valid=1 -> next clk level 0, row not taken, px_valid 0;
//    then rst during pops -> px_valid 0, level 0, px_out 0, no stale pixel after release.
//  6 Wrap: alternate push/pop 5 rows with pop_en toggling -> output order matches push order
//    across pointer wrap at 16.

Source files
------------

// File: rtl/ppu_pixel_fifo.sv
// PPU pixel FIFO: takes whole bitplane tile rows, emits one pixel per cycle with SCX discard.
// Optional PPU_FIFO_PALETTE_EN maps colour index to palette shade inside the FIFO.
module ppu_pixel_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ROW_W  = 8,
    parameter int unsigned PLANES = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [2:0]                      discard_n_i,
    input  logic [PLANES*ROW_W-1:0]         row_data_i,
    input  logic                            row_valid_i,
    output logic                            row_ready_o,
    input  logic                            pop_en_i,
    input  logic [(1<<PLANES)*PLANES-1:0]   palette_i,
    output logic [PLANES-1:0]               px_out_o,
    output logic                            px_valid_o,
    output logic [$clog2(DEPTH):0]          level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] PushLimit = LW'(DEPTH - ROW_W);
    localparam logic [LW-1:0] RowInc    = LW'(ROW_W);

    logic [PLANES-1:0] mem_q [DEPTH];
    logic [PLANES-1:0] row_pix [DEPTH];
    logic [AW-1:0]     wr_off [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [2:0]        discard_q, discard_d;
    logic [PLANES-1:0] px_out_q, px_out_d;
    logic              px_valid_q, px_valid_d;
    logic              push, pop;
    logic [PLANES-1:0] head_pix, head_px;

    assign row_ready_o = !flush_i && !rst_i && (level_q <= PushLimit);
    assign push        = row_valid_i && row_ready_o;
    assign pop         = pop_en_i && (level_q != '0) && !flush_i;
    assign head_pix    = mem_q[rd_ptr_q];

`ifdef PPU_FIFO_PALETTE_EN
    assign head_px = palette_i[int'(head_pix)*PLANES +: PLANES];
`else
    logic unused_palette;
    assign unused_palette = ^palette_i;
    assign head_px        = head_pix;
`endif

    // Pixel k of the row is bit ROW_W-1-k of every plane (leftmost pixel first).
    always_comb begin
        row_pix = '{default: '0};
        wr_off  = '{default: '0};
        for (int k = 0; k < int'(ROW_W); k++) begin
            for (int p = 0; p < int'(PLANES); p++) begin
                row_pix[k][p] = row_data_i[p*ROW_W + (ROW_W - 1 - k)];
            end
        end
        for (int e = 0; e < int'(DEPTH); e++) begin
            wr_off[e] = AW'(e) - wr_ptr_q;
        end
    end

    // Each entry decides locally whether it falls inside the row window being written.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (push && (LW'(wr_off[e]) < RowInc)) begin
                mem_q[e] <= row_pix[wr_off[e]];
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        discard_d  = discard_q;
        px_out_d   = px_out_q;
        px_valid_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            discard_d = discard_n_i;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(ROW_W);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (discard_q != '0) begin
                    discard_d = discard_q - 3'd1;
                end else begin
                    px_out_d   = head_px;
                    px_valid_d = 1'b1;
                end
            end
            level_d = level_q + (push ? RowInc : '0) - (pop ? LW'(1) : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            discard_q  <= '0;
            px_out_q   <= '0;
            px_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            discard_q  <= discard_d;
            px_out_q   <= px_out_d;
            px_valid_q <= px_valid_d;
        end
    end

    assign px_out_o   = px_out_q;
    assign px_valid_o = px_valid_q;
    assign level_o    = level_q;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Bench for ppu_pixel_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_ppu_pixel_fifo;

    localparam int DEPTH  = 16;
    localparam int ROW_W  = 8;
    localparam int PLANES = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          flush = 1'b0;
    logic [2:0]                    discard_n = '0;
    logic [PLANES*ROW_W-1:0]       row_data = '0;
    logic                          row_valid = 1'b0;
    logic                          row_ready;
    logic                          pop_en = 1'b0;
    logic [(1<<PLANES)*PLANES-1:0] palette = 8'hE4;
    logic [PLANES-1:0]             px_out;
    logic                          px_valid;
    logic [$clog2(DEPTH):0]        level;

    int checks = 0;
    int failures = 0;

    // Reference model: plain queue of colour indices plus the discard counter.
    int q[$];
    int seen[$];
    int m_disc = 0;
    int m_px = 0;
    int m_pv = 0;

    always #5 clk = ~clk;

    ppu_pixel_fifo #(.DEPTH(DEPTH), .ROW_W(ROW_W), .PLANES(PLANES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .discard_n_i (discard_n),
        .row_data_i  (row_data),
        .row_valid_i (row_valid),
        .row_ready_o (row_ready),
        .pop_en_i    (pop_en),
        .palette_i   (palette),
        .px_out_o    (px_out),
        .px_valid_o  (px_valid),
        .level_o     (level)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int map_px(input int idx);
`ifdef PPU_FIFO_PALETTE_EN
        return int'((palette >> (idx * PLANES)) & 8'h3);
`else
        return idx;
`endif
    endfunction

    // Inputs are set by the caller; check ready, clock once, update model, check outputs.
    task automatic cycle();
        bit rdy;
        int old;
        int pix;
        #1;
        rdy = !flush && !rst && (q.size() <= DEPTH - ROW_W);
        check_val("row_ready", {31'd0, row_ready}, {31'd0, rdy});
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_disc = 0;
            m_px = 0;
            m_pv = 0;
        end else if (flush) begin
            q.delete();
            m_disc = int'(discard_n);
            m_pv = 0;
        end else begin
            m_pv = 0;
            if (pop_en && q.size() != 0) begin
                old = q.pop_front();
                if (m_disc > 0) begin
                    m_disc--;
                end else begin
                    m_px = map_px(old);
                    m_pv = 1;
                end
            end
            if (row_valid && rdy) begin
                for (int k = 0; k < ROW_W; k++) begin
                    pix = 0;
                    for (int p = 0; p < PLANES; p++) begin
                        pix |= int'(row_data[p*ROW_W + ROW_W - 1 - k]) << p;
                    end
                    q.push_back(pix);
                end
            end
        end
        #1;
        check_val("px_valid", {31'd0, px_valid}, m_pv);
        check_val("px_out", {30'd0, px_out}, m_px);
        check_val("level", {27'd0, level}, q.size());
        if (px_valid) seen.push_back(int'(px_out));
    endtask

    initial begin
        int exp1[8];
        int exp4[5];
        exp1 = '{3, 3, 1, 1, 2, 2, 0, 0};
        exp4 = '{1, 2, 2, 0, 0};

        repeat (2) cycle();
        rst = 1'b0;
        check_val("reset_level", {27'd0, level}, 0);
        check_val("reset_valid", {31'd0, px_valid}, 0);

        // Single row drained at one pixel per clock.
        row_data = 16'hCCF0;
        row_valid = 1'b1;
        pop_en = 1'b1;
        cycle();
        row_valid = 1'b0;
        seen.delete();
        repeat (9) cycle();
        check_val("t1_count", seen.size(), 8);
`ifndef PPU_FIFO_PALETTE_EN
        for (int i = 0; i < 8 && i < seen.size(); i++) check_val("t1_pixel", seen[i], exp1[i]);
`endif

        // Fill to full, hold a third row, then drain with concurrent pushes.
        pop_en = 1'b0;
        row_valid = 1'b1;
        row_data = 16'h5AA5;
        repeat (4) cycle();
        check_val("t3_full", {27'd0, level}, DEPTH);
        check_val("t3_ready", {31'd0, row_ready}, 0);
        pop_en = 1'b1;
        repeat (12) cycle();
        row_valid = 1'b0;
        repeat (20) cycle();

        // Flush with SCX discard of three pixels.
        flush = 1'b1;
        discard_n = 3'd3;
        cycle();
        flush = 1'b0;
        row_data = 16'hCCF0;
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        seen.delete();
        repeat (9) cycle();
        check_val("t4_count", seen.size(), 5);
`ifndef PPU_FIFO_PALETTE_EN
        for (int i = 0; i < 5 && i < seen.size(); i++) check_val("t4_pixel", seen[i], exp4[i]);
`endif

        // Flush at level 12 with a row offered, then reset during pops.
        pop_en = 1'b0;
        row_valid = 1'b1;
        repeat (2) cycle();
        row_valid = 1'b0;
        pop_en = 1'b1;
        repeat (4) cycle();
        check_val("t5_level12", {27'd0, level}, 12);
        flush = 1'b1;
        discard_n = 3'd0;
        row_valid = 1'b1;
        cycle();
        flush = 1'b0;
        row_valid = 1'b0;
        check_val("t5_flushed", {27'd0, level}, 0);
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("t5_rst_px", {30'd0, px_out}, 0);
        seen.delete();
        repeat (6) cycle();
        check_val("t5_no_stale", seen.size(), 0);

        // Pointer wrap: five rows with toggling consumer.
        for (int r = 0; r < 5; r++) begin
            row_data = 16'($urandom);
            row_valid = 1'b1;
            pop_en = 1'($urandom);
            cycle();
            row_valid = 1'b0;
            repeat (10) begin
                pop_en = 1'($urandom);
                cycle();
            end
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            discard_n = 3'($urandom);
            row_valid = 1'($urandom);
            row_data = 16'($urandom);
            pop_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) palette = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
